// File: rtl/qspi_flash_pkg.sv
// rtl/qspi_flash_pkg.sv - shared types and constants for the quad-SPI line fetcher
package qspi_flash_pkg;

    // Transaction phases, in the order they occur on the bus
    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        MODE,
        DUMMY,
        DATA,
        CSH
    } state_t;

    localparam logic [7:0] CMD_QIO_READ = 8'hEB;

    // HOLD# and WP# stay high whenever the pads are not carrying quad data
    localparam logic [3:0] SIO_IDLE = 4'b1100;

    // Bytes arrive lowest address first and land MSB-first in the shifter;
    // swap lanes so the first byte ends up in bits [7:0]
    function automatic logic [31:0] le_word(input logic [31:0] be);
        return {be[7:0], be[15:8], be[23:16], be[31:24]};
    endfunction

endpackage

// File: rtl/qspi_flash_line_fetch_if.sv
// rtl/qspi_flash_line_fetch_if.sv - cache request bus and flash pad bundle
interface qspi_flash_line_fetch_if;
    logic        req;
    logic [23:0] addr;
    logic        busy;
    logic [31:0] rdata;
    logic        rvalid;
    logic        done;
    logic [3:0]  fdi;
    logic [3:0]  fdo;
    logic        fdoe;
    logic        fsclk;
    logic        fcen;

    modport slave (
        input  req, addr, fdi,
        output busy, rdata, rvalid, done, fdo, fdoe, fsclk, fcen
    );

    modport master (
        output req, addr, fdi,
        input  busy, rdata, rvalid, done, fdo, fdoe, fsclk, fcen
    );
endinterface

// File: rtl/qspi_nibble_shifter.sv
// rtl/qspi_nibble_shifter.sv - 32-bit serial/quad shift register with byte-lane reorder
module qspi_nibble_shifter
    import qspi_flash_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] load_data_i,
    input  logic        shift1_i,
    input  logic        shift4_i,
    input  logic [3:0]  nib_i,
    output logic [3:0]  top_o,
    output logic [31:0] word_o
);
    logic [31:0] sh_q;
    logic [31:0] sh_d;

    // Load wins over shifting; quad shift also serves quad shift-in
    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = load_data_i;
        end else if (shift4_i) begin
            sh_d = {sh_q[27:0], nib_i};
        end else if (shift1_i) begin
            sh_d = {sh_q[30:0], 1'b0};
        end
    end

    // Shift register state
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign top_o  = sh_q[31:28];
    // Word as it will look once the nibble on nib_i is shifted in, so the
    // caller can register it on the same edge that captures the 8th nibble
    assign word_o = le_word({sh_q[27:0], nib_i});

endmodule

// File: rtl/qspi_flash_line_fetch.sv
// rtl/qspi_flash_line_fetch.sv - Fast Read Quad I/O line fetch sequencer
module qspi_flash_line_fetch #(
    parameter int         LINE_WORDS = 4,
    parameter int         DUMMY_CLKS = 4,
    parameter logic [7:0] MODE_BYTE  = 8'h00,
    parameter int         CSH_CYCLES = 2
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    qspi_flash_line_fetch_if.slave bus
);
    import qspi_flash_pkg::*;

    localparam int DATA_CLKS = LINE_WORDS * 8;
    localparam int CNT_W     = $clog2((DATA_CLKS > 8) ? DATA_CLKS : 8);
    localparam int CSH_W     = (CSH_CYCLES > 1) ? $clog2(CSH_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(5);
    localparam logic [CNT_W-1:0] MODE_LAST  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CLKS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_CLKS - 1);
    localparam logic [CSH_W-1:0] CSH_LAST   = CSH_W'(CSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CSH_W-1:0] csh_q, csh_d;
    logic             fsclk_q, fsclk_d;
    logic             fcen_q, fcen_d;
    logic [23:0]      addr_q, addr_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             done_q, done_d;

    logic             sh_load;
    logic [31:0]      sh_load_data;
    logic             sh_shift1;
    logic             sh_shift4;
    logic [3:0]       sh_top;
    logic [31:0]      sh_word;
    logic             sck_end;
    logic [3:0]       fdo_c;
    logic             fdoe_c;

    qspi_nibble_shifter u_shifter (
        .clk         (HCLK),
        .rst         (HRESET),
        .load_i      (sh_load),
        .load_data_i (sh_load_data),
        .shift1_i    (sh_shift1),
        .shift4_i    (sh_shift4),
        .nib_i       (bus.fdi),
        .top_o       (sh_top),
        .word_o      (sh_word)
    );

    // fsclk high means this edge closes an SCK period: flash has sampled
    // our outputs and its data on fdi is settled
    assign sck_end = fsclk_q;

    // Next-state, SCK counting and shifter control
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        csh_d        = csh_q;
        fsclk_d      = 1'b0;
        fcen_d       = fcen_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;
        done_d       = 1'b0;
        sh_load      = 1'b0;
        sh_load_data = '0;
        sh_shift1    = 1'b0;
        sh_shift4    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    addr_d       = bus.addr & 24'hFFFFFC;
                    fcen_d       = 1'b0;
                    cnt_d        = '0;
                    sh_load      = 1'b1;
                    sh_load_data = {CMD_QIO_READ, 24'h000000};
                    state_d      = CMD;
                end
            end
            CMD: begin
                fsclk_d = ~fsclk_q;
                if (sck_end) begin
                    if (cnt_q == CMD_LAST) begin
                        // Address and mode byte go out back to back as 8 nibbles
                        cnt_d        = '0;
                        sh_load      = 1'b1;
                        sh_load_data = {addr_q, MODE_BYTE};
                        state_d      = ADDR;
                    end else begin
                        cnt_d     = cnt_q + CNT_W'(1);
                        sh_shift1 = 1'b1;
                    end
                end
            end
            ADDR: begin
                fsclk_d = ~fsclk_q;
                if (sck_end) begin
                    sh_shift4 = 1'b1;
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = MODE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            MODE: begin
                fsclk_d = ~fsclk_q;
                if (sck_end) begin
                    sh_shift4 = 1'b1;
                    if (cnt_q == MODE_LAST) begin
                        cnt_d   = '0;
                        state_d = DUMMY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DUMMY: begin
                fsclk_d = ~fsclk_q;
                if (sck_end) begin
                    if (cnt_q == DUMMY_LAST) begin
                        cnt_d   = '0;
                        state_d = DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                fsclk_d = ~fsclk_q;
                if (sck_end) begin
                    sh_shift4 = 1'b1;
                    if (cnt_q[2:0] == 3'd7) begin
                        rvalid_d = 1'b1;
                        rdata_d  = sh_word;
                    end
                    if (cnt_q == DATA_LAST) begin
                        done_d  = 1'b1;
                        fcen_d  = 1'b1;
                        fsclk_d = 1'b0;
                        cnt_d   = '0;
                        csh_d   = '0;
                        state_d = CSH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            CSH: begin
                if (csh_q == CSH_LAST) begin
                    state_d = IDLE;
                end else begin
                    csh_d = csh_q + CSH_W'(1);
                end
            end
            default: begin
                fcen_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State and pad registers; reset releases the flash immediately
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            csh_q    <= '0;
            fsclk_q  <= 1'b0;
            fcen_q   <= 1'b1;
            addr_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            csh_q    <= csh_d;
            fsclk_q  <= fsclk_d;
            fcen_q   <= fcen_d;
            addr_q   <= addr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
        end
    end

    // SIO drive: single-bit command on SIO0, quad address/mode, released otherwise
    always_comb begin
        fdo_c  = SIO_IDLE;
        fdoe_c = 1'b0;
        case (state_q)
            CMD: begin
                fdo_c  = {SIO_IDLE[3:1], sh_top[3]};
                fdoe_c = 1'b1;
            end
            ADDR, MODE: begin
                fdo_c  = sh_top;
                fdoe_c = 1'b1;
            end
            default: begin
                fdo_c  = SIO_IDLE;
                fdoe_c = 1'b0;
            end
        endcase
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.done   = done_q;
    assign bus.fdo    = fdo_c;
    assign bus.fdoe   = fdoe_c;
    assign bus.fsclk  = fsclk_q;
    assign bus.fcen   = fcen_q;

endmodule

// File: tb/tb_qspi_flash_line_fetch.sv
// tb/tb_qspi_flash_line_fetch.sv - scoreboard bench with behavioural quad flash
`timescale 1ns/1ps
module tb_qspi_flash_line_fetch;

    logic HCLK = 1'b0;
    logic HRESET;

    qspi_flash_line_fetch_if bus ();

    qspi_flash_line_fetch dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Flash contents: identity for the low 64 KiB page, distinct near the top
    function automatic logic [7:0] fbyte(input logic [23:0] a);
        return a[7:0] ^ a[23:16];
    endfunction

    // Behavioural flash: samples/drives in the middle of SCK high phase
    int          m_sck = 0;
    int          m_n;
    logic [7:0]  m_b;
    logic [7:0]  m_cmd, last_cmd;
    logic [23:0] m_addr, last_addr;
    logic [7:0]  m_mode, last_mode;
    int          m_oe_bad = 0, last_oe_bad = 0;
    int          m_hold_bad = 0, last_hold_bad = 0;

    always @(negedge HCLK) begin
        if (bus.fcen !== 1'b0) begin
            if (m_sck != 0) begin
                last_cmd      = m_cmd;
                last_addr     = m_addr;
                last_mode     = m_mode;
                last_oe_bad   = m_oe_bad;
                last_hold_bad = m_hold_bad;
            end
            m_sck      = 0;
            m_oe_bad   = 0;
            m_hold_bad = 0;
            bus.fdi    = 4'h0;
        end else if (bus.fsclk === 1'b1) begin
            if (m_sck < 8) begin
                m_cmd = {m_cmd[6:0], bus.fdo[0]};
                if (bus.fdo[3:1] !== 3'b110) m_hold_bad++;
            end else if (m_sck < 14) begin
                m_addr = {m_addr[19:0], bus.fdo};
            end else if (m_sck < 16) begin
                m_mode = {m_mode[3:0], bus.fdo};
            end
            if ((m_sck < 16) ? (bus.fdoe !== 1'b1) : (bus.fdoe !== 1'b0)) m_oe_bad++;
            if (m_sck >= 20) begin
                m_n     = m_sck - 20;
                m_b     = fbyte(m_addr + 24'(m_n / 2));
                bus.fdi = m_n[0] ? m_b[3:0] : m_b[7:4];
            end
            m_sck++;
        end
    end

    // Scoreboard and observation state, all owned by the stimulus process
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   rv_t[$];
    int   cyc = 0, acc_cyc = 0, idle_t = 0, done_t = 0;
    int   n_acc = 0, n_done = 0, n_rvalid = 0, n_csh = 0, n_idle = 0;
    logic busy_prev = 1'b0;

    task automatic push_line(input logic [23:0] a);
        logic [23:0] base;
        logic [31:0] d;
        base = {a[23:2], 2'b00};
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 4; k++) d[8*k +: 8] = fbyte(base + 24'(4*w + k));
            exp_q.push_back('{data: d, last: (w == 3)});
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge HCLK);
        cyc++;
        if (bus.busy && !busy_prev) begin
            n_acc++;
            acc_cyc = cyc;
        end
        if (!bus.busy && busy_prev) idle_t = cyc - acc_cyc + 1;
        busy_prev = bus.busy;
        if (bus.fcen && bus.busy) n_csh++;
        if (!bus.busy) n_idle++;
        if (bus.rvalid) begin
            n_rvalid++;
            rv_t.push_back(cyc - acc_cyc + 1);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_rvalid", 32'(bus.rvalid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("rdata", bus.rdata, e.data);
                check_eq("done_with_word", 32'(bus.done), 32'(e.last));
            end
        end else if (bus.done) begin
            check_eq("done_without_rvalid", 32'(bus.rvalid), 32'd1);
        end
        if (bus.done) begin
            n_done++;
            done_t = cyc - acc_cyc + 1;
        end
    endtask

    task automatic wait_done(input int max, input string tag);
        int d0;
        int i;
        d0 = n_done;
        i  = 0;
        while (n_done == d0 && i < max) begin
            tick();
            i++;
        end
        check_eq(tag, 32'(n_done != d0), 32'd1);
    endtask

    task automatic wait_busy(input logic lvl, input int max, input string tag);
        int i;
        i = 0;
        while (bus.busy !== lvl && i < max) begin
            tick();
            i++;
        end
        check_eq(tag, 32'(bus.busy), 32'(lvl));
    endtask

    task automatic check_pins(input logic [23:0] exp_addr, input string tag);
        check_eq({tag, "_cmd_bits"}, 32'(last_cmd), 32'h000000EB);
        check_eq({tag, "_addr"}, 32'(last_addr), 32'(exp_addr));
        check_eq({tag, "_mode"}, 32'(last_mode), 32'h00000000);
        check_eq({tag, "_fdoe"}, 32'(last_oe_bad), 32'd0);
        check_eq({tag, "_hold_wp"}, 32'(last_hold_bad), 32'd0);
    endtask

    // One complete request with req dropped once busy is seen
    task automatic fetch(input logic [23:0] a, input string tag);
        push_line(a);
        bus.req  = 1'b1;
        bus.addr = a;
        wait_busy(1'b1, 20, {tag, "_accept"});
        bus.req = 1'b0;
        wait_done(200, {tag, "_done"});
        wait_busy(1'b0, 20, {tag, "_idle"});
    endtask

    int b0, a0, r0, d0;

    initial begin
        HRESET   = 1'b1;
        bus.req  = 1'b0;
        bus.addr = '0;
        repeat (3) tick();

        check_eq("rst_fcen", 32'(bus.fcen), 32'd1);
        check_eq("rst_fsclk", 32'(bus.fsclk), 32'd0);
        check_eq("rst_fdoe", 32'(bus.fdoe), 32'd0);
        check_eq("rst_fdo", 32'(bus.fdo), 32'hC);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_rdata", bus.rdata, 32'h0);
        HRESET = 1'b0;
        repeat (2) tick();

        // Line at 0: data, latency and pin activity
        b0 = rv_t.size();
        push_line(24'h000000);
        bus.req  = 1'b1;
        bus.addr = 24'h000000;
        wait_busy(1'b1, 20, "t1_accept");
        check_eq("t1_fcen_low_edge1", 32'(bus.fcen), 32'd0);
        bus.req = 1'b0;
        wait_done(200, "t1_done");
        wait_busy(1'b0, 20, "t1_idle");
        check_eq("t1_rvalid_count", 32'(rv_t.size() - b0), 32'd4);
        if (rv_t.size() - b0 == 4) begin
            for (int i = 0; i < 4; i++) check_eq("t1_rvalid_edge", 32'(rv_t[b0 + i]), 32'(57 + 16*i));
        end
        check_eq("t1_done_edge", 32'(done_t), 32'd105);
        check_eq("t1_busy_low_edge", 32'(idle_t), 32'd107);
        check_pins(24'h000000, "t1");
        check_eq("t1_sb_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();

        // Unaligned address is rounded down to the word
        fetch(24'h000013, "t2");
        check_pins(24'h000010, "t2");
        repeat (3) tick();

        // req held across a whole transaction: one fetch, next only from IDLE
        a0 = n_acc;
        push_line(24'h000020);
        push_line(24'h000020);
        bus.req  = 1'b1;
        bus.addr = 24'h000020;
        wait_busy(1'b1, 20, "t4_accept");
        wait_done(200, "t4_done1");
        check_eq("t4_one_txn_while_busy", 32'(n_acc - a0), 32'd1);
        n_csh  = 1;
        n_idle = 0;
        r0     = n_acc;
        while (n_acc == r0 && n_idle < 20) tick();
        check_eq("t3_csh_cycles", 32'(n_csh), 32'd2);
        check_eq("t4_idle_before_second", 32'(n_idle), 32'd1);
        bus.req = 1'b0;
        b0 = rv_t.size();
        wait_done(200, "t4_done2");
        check_eq("t4_second_first_rvalid", 32'(rv_t[b0]), 32'd57);
        wait_busy(1'b0, 20, "t4_idle");
        repeat (10) tick();
        check_eq("t4_two_txn_total", 32'(n_acc - a0), 32'd2);
        check_pins(24'h000020, "t3");

        // Reset during the second word aborts cleanly
        push_line(24'h000080);
        bus.req  = 1'b1;
        bus.addr = 24'h000080;
        wait_busy(1'b1, 20, "t5_accept");
        bus.req = 1'b0;
        r0 = n_rvalid;
        for (int i = 0; i < 100 && n_rvalid == r0; i++) tick();
        repeat (8) tick();
        HRESET = 1'b1;
        tick();
        check_eq("t5_rst_fcen", 32'(bus.fcen), 32'd1);
        check_eq("t5_rst_fsclk", 32'(bus.fsclk), 32'd0);
        check_eq("t5_rst_busy", 32'(bus.busy), 32'd0);
        exp_q.delete();
        HRESET = 1'b0;
        r0 = n_rvalid;
        d0 = n_done;
        repeat (60) tick();
        check_eq("t5_no_rvalid_after_rst", 32'(n_rvalid - r0), 32'd0);
        check_eq("t5_no_done_after_rst", 32'(n_done - d0), 32'd0);
        fetch(24'h000040, "t5post");
        check_eq("t5post_done_edge", 32'(done_t), 32'd105);
        check_pins(24'h000040, "t5post");
        repeat (3) tick();

        // Top-of-array fetch wraps to address 0 inside the flash
        fetch(24'hFFFFF8, "t6");
        check_pins(24'hFFFFF8, "t6");
        check_eq("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
